// File: rtl/chan_capture_pkg.sv
// Shared types and field positions for the startBuffer capture controller.
// Bit indices refer to the software-written startBuffer control word.
package chan_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int START_BIT = 0;
  localparam int ABORT_BIT = 1;
  localparam int SYNC_BIT  = 2;
  localparam int LEN_LSB   = 16;

  localparam int STAT_BUSY_BIT  = 31;
  localparam int STAT_DONE_BIT  = 30;
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 16;

endpackage

// File: rtl/startbuffer_capture_ctrl_edge_detect.sv
// Per-bit rising-edge detector; history resets to one so bits already high
// when reset releases are not seen as edges.
module reg_edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '1;
    else        hist <= level;
  end

  assign rise = level & ~hist;

endmodule

// File: rtl/startbuffer_capture_ctrl.sv
// One-shot capture of len_m1+1 samples into a BRAM write port, armed by the
// startBuffer control word, with a status word for software readback.
module startbuffer_capture_ctrl
  import chan_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       start_reg,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              sync_in,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state, next_state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] len_m1;
  logic              start_pulse, abort_pulse;
  logic              accept_start, write_en, last_sample;
  logic              unused_bits;

  assign unused_bits = ^{start_reg[31:LEN_LSB+ADDR_W], start_reg[LEN_LSB-1:SYNC_BIT+1]};

  reg_edge_detect #(.W(1)) u_start_edge (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .level (start_reg[START_BIT]),
    .rise  (start_pulse)
  );

  reg_edge_detect #(.W(1)) u_abort_edge (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .level (start_reg[ABORT_BIT]),
    .rise  (abort_pulse)
  );

  // count is cleared on every accepted start, so it doubles as the sample index
  assign last_sample = (count == {1'b0, len_m1});

  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    write_en     = 1'b0;
    case (state)
      IDLE, DONE: begin
        // abort wins over a simultaneous start
        if (start_pulse && !abort_pulse) begin
          accept_start = 1'b1;
          next_state   = start_reg[SYNC_BIT] ? ARMED : CAPTURE;
        end
      end
      ARMED: begin
        if (abort_pulse) begin
          next_state = IDLE;
        end else if (data_valid && sync_in) begin
          write_en   = 1'b1;
          next_state = last_sample ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort_pulse) begin
          next_state = IDLE;
        end else if (data_valid) begin
          write_en = 1'b1;
          if (last_sample) next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      count     <= '0;
      len_m1    <= '0;
    end else begin
      state   <= next_state;
      busy    <= (next_state == ARMED) || (next_state == CAPTURE);
      done    <= (next_state == DONE);
      bram_we <= write_en;
      if (accept_start) begin
        len_m1    <= start_reg[LEN_LSB +: ADDR_W];
        count     <= '0;
        bram_addr <= '0;
      end
      if (write_en) begin
        bram_din  <= data_in;
        bram_addr <= count[ADDR_W-1:0];
        count     <= count + 1'b1;
      end
    end
  end

  assign status = {busy, done, 14'b0, {(STAT_COUNT_W-CNT_W){1'b0}}, count};

endmodule

// File: tb/tb_startbuffer_capture_ctrl.sv
// Bench for startbuffer_capture_ctrl: directed and randomized captures checked
// against a sample-list model of which valid samples land at which address.
module tb_startbuffer_capture_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              user_clk = 1'b0;
  logic              user_rst_n = 1'b0;
  logic [31:0]       start_reg = 32'h0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              sync_in = 1'b0;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic              busy;
  logic              done;
  logic [31:0]       status;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] got_addr_q[$];
  logic [DATA_W-1:0] got_data_q[$];
  logic [DATA_W-1:0] exp_q[$];

  startbuffer_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .start_reg  (start_reg),
    .data_in    (data_in),
    .data_valid (data_valid),
    .sync_in    (sync_in),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_we    (bram_we),
    .busy       (busy),
    .done       (done),
    .status     (status)
  );

  // clock / reset
  always #5 user_clk = ~user_clk;

  // write monitor samples on the falling edge
  always @(negedge user_clk) begin
    if (user_rst_n && bram_we) begin
      got_addr_q.push_back(bram_addr);
      got_data_q.push_back(bram_din);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] w);
    data_valid = 1'b0;
    sync_in    = 1'b0;
    start_reg  = 32'h0;
    tick();
    start_reg = w;
    tick();
  endtask

  task automatic clear_q();
    got_addr_q.delete();
    got_data_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    user_rst_n = 1'b0;
    start_reg  = 32'h0000_0001;
    #12;
    checks++;
    if ({bram_we, bram_addr, bram_din, busy, done, status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%0b addr=%0h din=%0h busy=%0b done=%0b status=%h, want all zero",
               bram_we, bram_addr, bram_din, busy, done, status);
    end
    @(negedge user_clk);
    user_rst_n = 1'b1;
    tick();
    clear_q();
    for (int i = 0; i < 20; i++) begin
      data_valid = 1'b1;
      data_in    = $urandom;
      tick();
    end
    data_valid = 1'b0;
    tick();
    checks++;
    if (got_data_q.size() != 0) begin
      errors++;
      $display("FAIL held_start_writes: got %0d writes, want 0", got_data_q.size());
    end
    checks++;
    if ({busy, done, status} !== '0) begin
      errors++;
      $display("FAIL held_start_idle: busy=%0b done=%0b status=%h, want 0 0 0", busy, done, status);
    end
    start_reg = 32'h0;
    tick();
    start_reg = 32'h0000_0001;
    tick();
    checks++;
    if (busy !== 1'b1 || status !== 32'h8000_0000) begin
      errors++;
      $display("FAIL fresh_start: busy=%0b status=%h, want 1 80000000", busy, status);
    end
    start_reg = 32'h0000_0003;
    tick();
    tick();
    start_reg = 32'h0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_test_abort: busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_continuous();
    clear_q();
    do_start(32'h0003_0001);
    for (int i = 0; i < 8; i++) begin
      if (i >= 1 && i <= 4) begin
        checks++;
        if (bram_we !== 1'b1 || bram_din !== DATA_W'(32'h100 + i - 1) || bram_addr !== ADDR_W'(i - 1)) begin
          errors++;
          $display("FAIL write_latency[%0d]: we=%0b addr=%0d din=%h, want 1 %0d %h",
                   i, bram_we, bram_addr, bram_din, i - 1, 32'h100 + i - 1);
        end
      end
      data_valid = 1'b1;
      data_in    = DATA_W'(32'h100 + i);
      if (i < 4) exp_q.push_back(DATA_W'(32'h100 + i));
      tick();
    end
    data_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (got_data_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL cont_count: got %0d writes, want %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL cont_write[%0d]: addr=%0d data=%h, want %0d %h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || status !== 32'h4000_0004) begin
      errors++;
      $display("FAIL cont_status: done=%0b busy=%0b status=%h, want 1 0 40000004", done, busy, status);
    end
  endtask

  task automatic test_wait_sync();
    clear_q();
    do_start(32'h0001_0005);
    sync_in = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || got_data_q.size() != 0) begin
          errors++;
          $display("FAIL armed_wait: busy=%0b done=%0b writes=%0d, want 1 0 0", busy, done, got_data_q.size());
        end
      end
      data_valid = 1'b1;
      sync_in    = (i == 6);
      data_in    = $urandom;
      if (i == 6 || i == 7) exp_q.push_back(data_in);
      tick();
    end
    data_valid = 1'b0;
    sync_in    = 1'b0;
    tick();
    tick();
    checks++;
    if (got_data_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sync_count: got %0d writes, want %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sync_write[%0d]: addr=%0d data=%h, want %0d %h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || status !== 32'h4000_0002) begin
      errors++;
      $display("FAIL sync_status: done=%0b status=%h, want 1 40000002", done, status);
    end
  endtask

  task automatic test_gapped();
    logic prev_we;
    int   taken;
    clear_q();
    do_start(32'h0005_0001);
    prev_we = 1'b0;
    taken   = 0;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (bram_we !== prev_we) begin
        errors++;
        $display("FAIL gap_we[%0d]: we=%0b, want %0b", c, bram_we, prev_we);
      end
      data_valid = (c % 2 == 0);
      data_in    = $urandom;
      prev_we    = data_valid && (taken < 6);
      if (prev_we) begin
        exp_q.push_back(data_in);
        taken++;
      end
      tick();
    end
    data_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (got_data_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gap_count: got %0d writes, want %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_write[%0d]: addr=%0d data=%h, want %0d %h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
      end
    end
    checks++;
    if (status !== 32'h4000_0006) begin
      errors++;
      $display("FAIL gap_status: status=%h, want 40000006", status);
    end
  endtask

  task automatic test_abort();
    clear_q();
    do_start(32'h0009_0001);
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data_in    = $urandom;
      exp_q.push_back(data_in);
      if (i == 2) start_reg = 32'h0009_0000;
      tick();
    end
    start_reg = 32'h0009_0003;
    for (int i = 0; i < 6; i++) begin
      data_valid = 1'b1;
      data_in    = $urandom;
      tick();
    end
    data_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (got_data_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_count: got %0d writes, want %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_write[%0d]: addr=%0d data=%h, want %0d %h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
      end
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== 32'h0000_0003) begin
      errors++;
      $display("FAIL abort_status: busy=%0b done=%0b status=%h, want 0 0 00000003", busy, done, status);
    end
    start_reg = 32'h0;
  endtask

  task automatic test_full_depth();
    clear_q();
    do_start(32'h03FF_0001);
    for (int i = 0; i < 1030; i++) begin
      data_valid = 1'b1;
      data_in    = $urandom;
      if (i < 1024) exp_q.push_back(data_in);
      tick();
    end
    data_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (got_data_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL full_count: got %0d writes, want %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_write[%0d]: addr=%0d data=%h, want %0d %h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || status !== 32'h4000_0400) begin
      errors++;
      $display("FAIL full_status: done=%0b status=%h, want 1 40000400", done, status);
    end
    // restart from DONE with a short length
    clear_q();
    do_start(32'h0002_0001);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rearm: done=%0b busy=%0b, want 0 1", done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      data_valid = 1'b1;
      data_in    = $urandom;
      if (i < 3) exp_q.push_back(data_in);
      tick();
    end
    data_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (got_data_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rearm_count: got %0d writes, want %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rearm_write[%0d]: addr=%0d data=%h, want %0d %h", i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || status !== 32'h4000_0003) begin
      errors++;
      $display("FAIL rearm_status: done=%0b status=%h, want 1 40000003", done, status);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] vdata[$];
    bit                vsync[$];
    int                len, ws, first, n_exp;
    bit                exp_done;
    logic [31:0]       exp_status;
    for (int it = 0; it < 6; it++) begin
      clear_q();
      vdata.delete();
      vsync.delete();
      len = $urandom_range(0, 15);
      ws  = $urandom_range(0, 1);
      do_start({6'b0, 10'(len), 13'b0, 1'(ws), 2'b01});
      for (int c = 0; c < 40; c++) begin
        data_valid = ($urandom_range(0, 3) != 0);
        sync_in    = ($urandom_range(0, 3) == 0);
        data_in    = $urandom;
        if (data_valid) begin
          vdata.push_back(data_in);
          vsync.push_back(sync_in);
        end
        tick();
      end
      data_valid = 1'b0;
      sync_in    = 1'b0;
      tick();
      tick();
      // model: capture starts at the first valid sample (or first valid sync)
      first = ws ? -1 : 0;
      if (ws) begin
        for (int k = 0; k < vsync.size(); k++) begin
          if (vsync[k] && first < 0) first = k;
        end
      end
      n_exp = 0;
      if (first >= 0) n_exp = (vdata.size() - first < len + 1) ? vdata.size() - first : len + 1;
      for (int k = 0; k < n_exp; k++) exp_q.push_back(vdata[first + k]);
      exp_done   = (n_exp == len + 1);
      exp_status = {!exp_done, exp_done, 14'b0, 16'(n_exp)};
      checks++;
      if (got_data_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d writes, want %0d", it, got_data_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
        checks++;
        if (got_addr_q[i] !== ADDR_W'(i) || got_data_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_write[%0d.%0d]: addr=%0d data=%h, want %0d %h",
                   it, i, got_addr_q[i], got_data_q[i], i, exp_q[i]);
        end
      end
      checks++;
      if (status !== exp_status) begin
        errors++;
        $display("FAIL rand_status[%0d]: status=%h, want %h", it, status, exp_status);
      end
      if (!exp_done) begin
        start_reg = start_reg | 32'h2;
        tick();
        tick();
      end
      start_reg = 32'h0;
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_wait_sync();
    test_gapped();
    test_abort();
    test_full_depth();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
